// File: rtl/control_pkg.sv
// Shared encodings for the multicycle controller, instruction register and ALU control.
package control_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode classifier feeding the DECODE transition.
module control_decode
  import control_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_rtype,
  output logic       is_addi,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_j,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    is_rtype   = 1'b0;
    is_addi    = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_beq     = 1'b0;
    is_j       = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: is_rtype = 1'b1;
      OP_ADDI:                       is_addi  = 1'b1;
      OP_LW:                         is_lw    = 1'b1;
      OP_SW:                         is_sw    = 1'b1;
      OP_BEQ:                        is_beq   = 1'b1;
      OP_J:                          is_j     = 1'b1;
      OP_HALT:                       is_halt  = 1'b1;
      default:                       is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath enables.
module multicycle_control
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       halted,
  output logic       illegal
);

  state_t state, state_next;
  logic   mem_is_lw, mem_is_lw_next;
  logic   is_rtype, is_addi, is_lw, is_sw, is_beq, is_j, is_halt, is_illegal;

  control_decode u_decode (
    .opcode     (opcode),
    .is_rtype   (is_rtype),
    .is_addi    (is_addi),
    .is_lw      (is_lw),
    .is_sw      (is_sw),
    .is_beq     (is_beq),
    .is_j       (is_j),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // opcode is only trusted in DECODE, so the lw/sw split is remembered for MEM_ADDR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      mem_is_lw <= 1'b0;
    end else begin
      state     <= state_next;
      mem_is_lw <= mem_is_lw_next;
    end
  end

  always_comb begin
    state_next     = state;
    mem_is_lw_next = mem_is_lw;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_ONE;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB        = SRCB_BR;
        mem_is_lw_next = is_lw;
        if (is_rtype)              state_next = S_EXEC_R;
        else if (is_addi)          state_next = S_EXEC_I;
        else if (is_lw || is_sw)   state_next = S_MEM_ADDR;
        else if (is_beq)           state_next = S_BRANCH;
        else if (is_j)             state_next = S_JUMP;
        else if (is_halt)          state_next = S_HALT;
        else begin
          illegal    = is_illegal;
          state_next = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALUOP_FUNCT;
        state_next = S_WB_R;
      end
      S_WB_R, S_WB_I: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        state_next = S_WB_I;
      end
      S_MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        state_next = mem_is_lw ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        state_next  = S_FETCH;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        state_next = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

endmodule
